// File: rtl/ika2151_pkg.sv
// Shared constants and state encoding for the IKA2151 slot-cycle timing blocks.
`default_nettype none

package ika2151_pkg;

  localparam int CYC_W = 5;

  localparam logic [CYC_W-1:0] CYC_LAST = 5'd31;
  localparam logic [CYC_W-1:0] CYC_00   = 5'd0;
  localparam logic [CYC_W-1:0] CYC_16   = 5'd16;
  localparam logic [CYC_W-1:0] CYC_30   = 5'd30;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/ika2151_cycdec.sv
// Combinational slot-cycle decoder: next count in, the three cycle strobes out.
`default_nettype none

module ika2151_cycdec
  import ika2151_pkg::*;
(
  input  logic [CYC_W-1:0] cyc_next,
  output logic             cycle_30,
  output logic             cycle_00_16,
  output logic             cycle_00_to_15_n
);

  assign cycle_30         = (cyc_next == CYC_30);
  assign cycle_00_16      = (cyc_next == CYC_00) || (cyc_next == CYC_16);
  // Upper half of the frame is exactly the slots with the MSB set.
  assign cycle_00_to_15_n = cyc_next[CYC_W-1];

endmodule

`default_nettype wire

// File: rtl/ika2151_cyclegen.sv
// 32-slot cycle counter with registered cycle strobes, sample strobe and startup hold.
`default_nettype none

module ika2151_cyclegen
  import ika2151_pkg::*;
#(
  parameter int STARTUP_HOLD = 1
) (
  input  logic             i_EMUCLK,
  input  logic             i_MRST_n,
  input  logic             i_phi1_NCEN_n,
  input  logic             i_CYCLE_SYNC,
  output logic [CYC_W-1:0] o_CYCLE_CNT,
  output logic             o_CYCLE_30,
  output logic             o_CYCLE_00_16,
  output logic             o_CYCLE_00_TO_15_n,
  output logic             o_SAMPLE_STB,
  output logic             o_READY
);

  localparam state_t ST_RESET = (STARTUP_HOLD != 0) ? ST_INIT : ST_RUN;

  state_t           state;
  state_t           state_nxt;
  logic [CYC_W-1:0] cyc;
  logic [CYC_W-1:0] cyc_nxt;
  logic             advance;
  logic             boundary;
  logic             dec_30;
  logic             dec_00_16;
  logic             dec_00_to_15_n;

  assign advance  = ~i_phi1_NCEN_n;
  // A sync landing on slot 31 is still a single boundary.
  assign boundary = advance & (i_CYCLE_SYNC | (cyc == CYC_LAST));
  assign cyc_nxt  = i_CYCLE_SYNC ? CYC_00 : cyc + 5'd1;

  ika2151_cycdec u_cycdec (
    .cyc_next         (cyc_nxt),
    .cycle_30         (dec_30),
    .cycle_00_16      (dec_00_16),
    .cycle_00_to_15_n (dec_00_to_15_n)
  );

  always_ff @(posedge i_EMUCLK or negedge i_MRST_n) begin
    if (!i_MRST_n) state <= ST_RESET;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT: if (boundary) state_nxt = ST_RUN;
      ST_RUN:  state_nxt = ST_RUN;
      default: state_nxt = ST_RESET;
    endcase
  end

  always_ff @(posedge i_EMUCLK or negedge i_MRST_n) begin
    if (!i_MRST_n) begin
      cyc                <= CYC_00;
      o_CYCLE_30         <= 1'b0;
      o_CYCLE_00_16      <= (STARTUP_HOLD == 0);
      o_CYCLE_00_TO_15_n <= (STARTUP_HOLD != 0);
      o_SAMPLE_STB       <= 1'b0;
      o_READY            <= 1'b0;
    end else begin
      o_SAMPLE_STB <= boundary && (state_nxt == ST_RUN);
      if (advance) begin
        cyc     <= cyc_nxt;
        o_READY <= (state_nxt == ST_RUN);
        if (state_nxt == ST_RUN) begin
          o_CYCLE_30         <= dec_30;
          o_CYCLE_00_16      <= dec_00_16;
          o_CYCLE_00_TO_15_n <= dec_00_to_15_n;
        end else begin
          o_CYCLE_30         <= 1'b0;
          o_CYCLE_00_16      <= 1'b0;
          o_CYCLE_00_TO_15_n <= 1'b1;
        end
      end
    end
  end

  assign o_CYCLE_CNT = cyc;

endmodule

`default_nettype wire

// File: tb/tb_ika2151_cyclegen.sv
// Self-checking bench for ika2151_cyclegen, both STARTUP_HOLD settings side by side.
`default_nettype none

module tb_ika2151_cyclegen;

  logic       clk;
  logic       rst_n;
  logic       ncen_n;
  logic       csync;

  logic [4:0] cnt   [2];
  logic       c30   [2];
  logic       c0016 [2];
  logic       c_n   [2];
  logic       stb   [2];
  logic       ready [2];

  int tests;
  int fails;

  // Reference model: index 0 is STARTUP_HOLD=1, index 1 is STARTUP_HOLD=0.
  int m_cyc   [2];
  bit m_run   [2];
  bit m_ready [2];
  bit m_stb   [2];

  ika2151_cyclegen #(.STARTUP_HOLD(1)) dut_hold (
    .i_EMUCLK(clk), .i_MRST_n(rst_n), .i_phi1_NCEN_n(ncen_n), .i_CYCLE_SYNC(csync),
    .o_CYCLE_CNT(cnt[0]), .o_CYCLE_30(c30[0]), .o_CYCLE_00_16(c0016[0]),
    .o_CYCLE_00_TO_15_n(c_n[0]), .o_SAMPLE_STB(stb[0]), .o_READY(ready[0])
  );

  ika2151_cyclegen #(.STARTUP_HOLD(0)) dut_nohold (
    .i_EMUCLK(clk), .i_MRST_n(rst_n), .i_phi1_NCEN_n(ncen_n), .i_CYCLE_SYNC(csync),
    .o_CYCLE_CNT(cnt[1]), .o_CYCLE_30(c30[1]), .o_CYCLE_00_16(c0016[1]),
    .o_CYCLE_00_TO_15_n(c_n[1]), .o_SAMPLE_STB(stb[1]), .o_READY(ready[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cyc[i]   = 0;
      m_ready[i] = 0;
      m_stb[i]   = 0;
    end
    m_run[0] = 0;
    m_run[1] = 1;
  endfunction

  function automatic void model_edge(input bit adv, input bit sync);
    for (int i = 0; i < 2; i++) begin
      if (adv) begin
        bit bnd;
        bnd        = sync || (m_cyc[i] == 31);
        m_cyc[i]   = sync ? 0 : (m_cyc[i] + 1) % 32;
        if (bnd) m_run[i] = 1;
        m_ready[i] = m_run[i];
        m_stb[i]   = m_run[i] && bnd;
      end else begin
        m_stb[i] = 0;
      end
    end
  endfunction

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      int e30, e0016, en;
      e30   = (m_run[i] && m_cyc[i] == 30) ? 1 : 0;
      e0016 = (m_run[i] && (m_cyc[i] == 0 || m_cyc[i] == 16)) ? 1 : 0;
      en    = (!m_run[i] || m_cyc[i] >= 16) ? 1 : 0;
      chk($sformatf("cnt[%0d]", i),   int'(cnt[i]),   m_cyc[i]);
      chk($sformatf("c30[%0d]", i),   int'(c30[i]),   e30);
      chk($sformatf("c0016[%0d]", i), int'(c0016[i]), e0016);
      chk($sformatf("c_n[%0d]", i),   int'(c_n[i]),   en);
      chk($sformatf("stb[%0d]", i),   int'(stb[i]),   int'(m_stb[i]));
      chk($sformatf("ready[%0d]", i), int'(ready[i]), int'(m_ready[i]));
    end
  endtask

  task automatic tick(input bit en, input bit sync);
    ncen_n = ~en;
    csync  = sync;
    @(posedge clk);
    model_edge(en, sync);
    #1;
    check_all();
  endtask

  task automatic run_to(input int target);
    for (int k = 0; k < 40 && m_cyc[0] != target; k++) tick(1'b1, 1'b0);
    chk("run_to", m_cyc[0], target);
  endtask

  initial begin
    int nstb;
    tests  = 0;
    fails  = 0;
    rst_n  = 1'b0;
    ncen_n = 1'b1;
    csync  = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Startup hold: enable every 2nd clock, 31 advances with strobes inactive.
    for (int k = 0; k < 31; k++) begin
      tick(1'b1, 1'b0);
      chk("hold_ready", int'(ready[0]), 0);
      tick(1'b0, 1'b0);
    end
    tick(1'b1, 1'b0);
    chk("first_frame_cnt",   int'(cnt[0]),   0);
    chk("first_frame_ready", int'(ready[0]), 1);
    chk("first_frame_stb",   int'(stb[0]),   1);
    chk("first_frame_c0016", int'(c0016[0]), 1);
    tick(1'b0, 1'b0);
    chk("stb_one_clock", int'(stb[0]), 0);

    // Free-run three frames, counting sample strobes.
    nstb = 0;
    for (int k = 0; k < 96; k++) begin
      tick(1'b1, 1'b0);
      if (stb[0]) nstb++;
    end
    chk("three_frames_stb", nstb, 3);

    // Sync at cycle 9, then a full 32-slot frame.
    run_to(9);
    tick(1'b1, 1'b1);
    chk("sync9_cnt", int'(cnt[0]), 0);
    chk("sync9_stb", int'(stb[0]), 1);
    nstb = 0;
    for (int k = 0; k < 31; k++) begin
      tick(1'b1, 1'b0);
      if (stb[0]) nstb++;
    end
    chk("sync9_frame_nostb", nstb, 0);
    tick(1'b1, 1'b0);
    chk("sync9_frame_stb", int'(stb[0]), 1);

    // Sync at cycle 31 is a single boundary.
    run_to(31);
    tick(1'b1, 1'b1);
    chk("sync31_stb", int'(stb[0]), 1);
    tick(1'b1, 1'b0);
    chk("sync31_next_cnt", int'(cnt[0]), 1);
    chk("sync31_next_stb", int'(stb[0]), 0);

    // Sync without an advance is ignored.
    repeat (4) tick(1'b0, 1'b1);
    chk("sync_noadv_cnt", int'(cnt[0]), 1);

    // Asynchronous reset mid-frame.
    run_to(20);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    chk("nohold_c_n",   int'(c_n[1]),   0);
    chk("nohold_c0016", int'(c0016[1]), 1);
    for (int k = 1; k <= 31; k++) begin
      tick(1'b1, 1'b0);
      chk("rst_ready_low", int'(ready[0]), 0);
      if (k == 30) chk("nohold_first_c30", int'(c30[1]), 1);
      else         chk("nohold_c30_low",   int'(c30[1]), 0);
    end
    tick(1'b1, 1'b0);
    chk("rst_ready_high", int'(ready[0]), 1);

    // Randomized stimulus against the model.
    for (int k = 0; k < 600; k++) begin
      tick($urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/ika2151_cyclegen.md
# ika2151_cyclegen

Slot-cycle timing generator for the IKA2151 core. It produces the 32-slot cycle count and the decoded cycle strobes that the LFO, EG and operator blocks consume: `CYCLE_30`, `CYCLE_00_16` and `CYCLE_00_TO_15_n`. It also provides a once-per-sample strobe. It sits between the phi1 clock-enable generator and every slot-sequenced block, and is the driving end of the cycle-strobe interface those blocks receive.

## Interface
Parameters:
- `STARTUP_HOLD`, default 1. When 1, all strobes are held inactive until the first full 32-cycle frame completes after reset.

Ports:
- `i_EMUCLK`  in  1  emulator master clock; all state is clocked here.
- `i_MRST_n`  in  1  core internal reset, asynchronous, active-low.
- `i_phi1_NCEN_n`  in  1  phi1 negative-edge enable, active-low. It is the only advance qualifier.
- `i_CYCLE_SYNC`  in  1  synchronous realign request; forces the count to 0 at the next enable.
- `o_CYCLE_CNT`  out  5  current slot cycle, 0–31.
- `o_CYCLE_30`  out  1  high while cycle == 30.
- `o_CYCLE_00_16`  out  1  high while cycle == 0 or cycle == 16.
- `o_CYCLE_00_TO_15_n`  out  1  low while cycle is 0–15, high while cycle is 16–31.
- `o_SAMPLE_STB`  out  1  single-`i_EMUCLK` pulse on every frame boundary.
- `o_READY`  out  1  high once the state machine is in RUN.

## Operation
- Advance event: a rising edge of `i_EMUCLK` with `i_phi1_NCEN_n == 0`. Nothing else changes state.
- Counter:
  - 5-bit register `cyc`.
  - On each advance, `cyc <= cyc + 1`, wrapping from 31 to 0 (mod-32 arithmetic, no saturation).
  - If `i_CYCLE_SYNC` is high on an advance, `cyc <= 0` regardless of its current value.
  - `i_CYCLE_SYNC` asserted without an advance is ignored. It is not latched.
- Strobes:
  - All strobes are registered and computed from the next value of `cyc`, so each one changes on the same edge as `o_CYCLE_CNT`. No combinational decode reaches an output.
  - `o_CYCLE_30`, `o_CYCLE_00_16` and `o_CYCLE_00_TO_15_n` decode `cyc` as listed under Interface.
- Frame boundary: an advance where `cyc == 31`, or an advance with `i_CYCLE_SYNC` high.
  - The boundary raises `o_SAMPLE_STB` for exactly one `i_EMUCLK`.
  - A sync that lands on `cyc == 31` counts as one boundary, not two.
- State machine, two states:
  - INIT: strobes forced inactive (`o_CYCLE_30 = 0`, `o_CYCLE_00_16 = 0`, `o_CYCLE_00_TO_15_n = 1`, `o_SAMPLE_STB = 0`). `o_READY = 0`. `cyc` still counts.
  - INIT → RUN on the first frame boundary. The boundary strobe and the cycle-0 decodes are emitted on that same edge.
  - RUN: strobes follow the decode. `o_READY = 1`. There is no exit except reset.
  - With `STARTUP_HOLD = 0`, reset enters RUN directly.
- Reset values (async on `i_MRST_n` low):
  - `cyc = 0`, `o_CYCLE_CNT = 0`.
  - State INIT, or RUN when `STARTUP_HOLD = 0`.
  - `o_CYCLE_30 = 0`, `o_SAMPLE_STB = 0`, `o_READY = 0`.
  - `o_CYCLE_00_16 = 0` and `o_CYCLE_00_TO_15_n = 1` under `STARTUP_HOLD = 1`. Under `STARTUP_HOLD = 0` they are 1 and 0, the decode of cycle 0.
- Reset deassertion is treated as synchronous to `i_EMUCLK` by the integrator. The first advance after release moves the count to 1.

## Timing
- Latency: one `i_EMUCLK` edge from a qualifying enable to every output changing.
- Between enables, every output holds its value.
- Each strobe stays high for a whole slot: from the advance that enters the cycle until the advance that leaves it. `o_SAMPLE_STB` is the only pulse-width-1 output.
- Reset mid-frame: outputs go to their reset values immediately, without waiting for a clock edge. The frame is restarted from 0.

## Structure
- Shared package `ika2151_pkg`:
  - `CYC_W = 5`, `CYC_LAST = 31`.
  - Cycle constants `CYC_00`, `CYC_16`, `CYC_30`.
  - State encoding `ST_INIT`, `ST_RUN`.
- The decode logic lives in one sub-module, `ika2151_cycdec`. It is purely combinational: a 5-bit next-count in, the three strobes out. The parent registers its outputs.

## Test plan
- Reset release, `STARTUP_HOLD = 1`, enable every 2nd clock → strobes stay inactive for 31 advances. The 32nd advance gives `cyc = 0`, `o_READY = 1`, `o_SAMPLE_STB` for one clock, and `o_CYCLE_00_16 = 1`.
- Free-run 3 frames → `o_CYCLE_30` high only at `cyc = 30`. `o_CYCLE_00_16` high at 0 and 16. `o_CYCLE_00_TO_15_n` is 0 for 16 slots and 1 for 16 slots. Exactly 3 sample strobes.
- `i_CYCLE_SYNC` on the advance at `cyc = 9` → next `cyc = 0`, one `o_SAMPLE_STB`. The following frame is a full 32 slots.
- `i_CYCLE_SYNC` on the advance at `cyc = 31` → a single boundary, one strobe. Also sync held with `i_phi1_NCEN_n` high → no effect.
- `i_MRST_n` pulsed low at `cyc = 20` between clocks → outputs take reset values immediately. `o_READY = 0` until the next full frame.
- `STARTUP_HOLD = 0` → after reset, `o_CYCLE_00_TO_15_n = 0` and `o_CYCLE_00_16 = 1`. The first `o_CYCLE_30` comes on the 30th advance.
